// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and types for the MIPS ID/EX pipeline stage.
//   DEF_*    default widths for address, operand, control bundle and counter
//   ZERO_REG architectural register 0 (never hazards, never forwards)
//   fwd_e    EX operand source select
package pipe_pkg;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 8;
    localparam int DEF_CNT_W  = 16;
    localparam int ZERO_REG   = 0;
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side request bundle and EX-side result bundle of the ID/EX stage.
//   id_*  decoded instruction from ID, with id_valid/id_ready handshake
//   ex_*  registered instruction toward EX, with ex_valid/ex_ready handshake
//   slave  modport: the stage (consumes id_*, produces ex_*)
//   master modport: the surrounding pipeline (produces id_*, consumes ex_*)
interface id_ex_stage_if
    import pipe_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
);
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic [ADDR_W-1:0] id_rd;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_mem_read;
    logic              id_reg_write;
    logic [DATA_W-1:0] id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              ex_ready;
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_rs;
    logic [ADDR_W-1:0] ex_rt;
    logic [ADDR_W-1:0] ex_rd;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_mem_read;
    logic              ex_reg_write;

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_mem_read, id_reg_write, id_imm, id_ctrl, ex_ready,
        output id_ready, ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data,
               ex_imm, ex_ctrl, ex_mem_read, ex_reg_write
    );

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_mem_read, id_reg_write, id_imm, id_ctrl, ex_ready,
        input  id_ready, ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data,
               ex_imm, ex_ctrl, ex_mem_read, ex_reg_write
    );
endinterface

// File: rtl/id_ex_stage_hazard_fwd_unit.sv
// hazard_fwd_unit: combinational load-use hazard detection and EX operand forwarding selects.
//   i_ex_*            instruction currently held in the EX register
//   i_id_*            instruction presented by ID
//   i_mem_rd/_we      destination of the instruction in MEM
//   i_wb_addr/_we     writeback port
//   o_hazard          ID must stall one cycle behind a load
//   o_fwd_a/o_fwd_b   rs/rt source: register, WB or MEM (MEM is the younger producer)
module hazard_fwd_unit
    import pipe_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              i_ex_valid,
    input  logic              i_ex_mem_read,
    input  logic [ADDR_W-1:0] i_ex_rs,
    input  logic [ADDR_W-1:0] i_ex_rt,
    input  logic [ADDR_W-1:0] i_ex_rd,
    input  logic              i_id_uses_rs,
    input  logic              i_id_uses_rt,
    input  logic [ADDR_W-1:0] i_id_rs,
    input  logic [ADDR_W-1:0] i_id_rt,
    input  logic [ADDR_W-1:0] i_mem_rd,
    input  logic              i_mem_reg_write,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic              i_wb_we,
    output logic              o_hazard,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b
);
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

    logic w_load_in_ex;
    logic w_mem_ok;
    logic w_wb_ok;

    assign w_load_in_ex = i_ex_valid & i_ex_mem_read & (i_ex_rd != ZERO);
    assign w_mem_ok     = i_ex_valid & i_mem_reg_write & (i_mem_rd != ZERO);
    assign w_wb_ok      = i_ex_valid & i_wb_we & (i_wb_addr != ZERO);

    assign o_hazard = w_load_in_ex & ((i_id_uses_rs & (i_id_rs == i_ex_rd)) |
                                      (i_id_uses_rt & (i_id_rt == i_ex_rd)));

    assign o_fwd_a = (w_mem_ok & (i_mem_rd == i_ex_rs))  ? FWD_MEM :
                     (w_wb_ok  & (i_wb_addr == i_ex_rs)) ? FWD_WB  : FWD_REG;
    assign o_fwd_b = (w_mem_ok & (i_mem_rd == i_ex_rt))  ? FWD_MEM :
                     (w_wb_ok  & (i_wb_addr == i_ex_rt)) ? FWD_WB  : FWD_REG;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with valid/ready handshake, load-use stall,
// forwarding selects and writeback snooping of held operands.
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (slave)         id_* in / id_ready out, ex_* out / ex_ready in
//   i_rd1, i_rd2        register-file read data for id_rs/id_rt
//   i_flush             branch taken: kill the EX register and block capture
//   i_mem_rd/_reg_write MEM-stage producer
//   i_wb_addr/_we/_data writeback port (shared with the register file)
//   o_fwd_a, o_fwd_b    EX operand selects
//   o_stall_cnt         saturating count of load-use stall cycles
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    id_ex_stage_if.slave      bus,
    input  logic [DATA_W-1:0] i_rd1,
    input  logic [DATA_W-1:0] i_rd2,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_mem_rd,
    input  logic              i_mem_reg_write,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic              i_wb_we,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
    output logic [CNT_W-1:0]  o_stall_cnt
);
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

    logic              r_ex_valid;
    logic [ADDR_W-1:0] r_ex_rs;
    logic [ADDR_W-1:0] r_ex_rt;
    logic [ADDR_W-1:0] r_ex_rd;
    logic [DATA_W-1:0] r_ex_rs_data;
    logic [DATA_W-1:0] r_ex_rt_data;
    logic [DATA_W-1:0] r_ex_imm;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic              r_ex_mem_read;
    logic              r_ex_reg_write;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_hazard;
    logic w_id_ready;
    logic w_capture;
    logic w_wb_live;
    logic w_snoop_rs;
    logic w_snoop_rt;

    hazard_fwd_unit #(.ADDR_W(ADDR_W)) u_hfu (
        .i_ex_valid      (r_ex_valid),
        .i_ex_mem_read   (r_ex_mem_read),
        .i_ex_rs         (r_ex_rs),
        .i_ex_rt         (r_ex_rt),
        .i_ex_rd         (r_ex_rd),
        .i_id_uses_rs    (bus.id_uses_rs),
        .i_id_uses_rt    (bus.id_uses_rt),
        .i_id_rs         (bus.id_rs),
        .i_id_rt         (bus.id_rt),
        .i_mem_rd        (i_mem_rd),
        .i_mem_reg_write (i_mem_reg_write),
        .i_wb_addr       (i_wb_addr),
        .i_wb_we         (i_wb_we),
        .o_hazard        (w_hazard),
        .o_fwd_a         (o_fwd_a),
        .o_fwd_b         (o_fwd_b)
    );

    assign w_id_ready = ~i_flush & ~w_hazard & (~r_ex_valid | bus.ex_ready);
    assign w_capture  = bus.id_valid & w_id_ready;
    // A stalled EX instruction would otherwise miss a writeback that retires while it waits
    assign w_wb_live  = i_wb_we & (i_wb_addr != ZERO);
    assign w_snoop_rs = w_wb_live & (i_wb_addr == r_ex_rs);
    assign w_snoop_rt = w_wb_live & (i_wb_addr == r_ex_rt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid     <= 1'b0;
            r_ex_rs        <= '0;
            r_ex_rt        <= '0;
            r_ex_rd        <= '0;
            r_ex_rs_data   <= '0;
            r_ex_rt_data   <= '0;
            r_ex_imm       <= '0;
            r_ex_ctrl      <= '0;
            r_ex_mem_read  <= 1'b0;
            r_ex_reg_write <= 1'b0;
        end else if (i_flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_capture) begin
            r_ex_valid     <= 1'b1;
            r_ex_rs        <= bus.id_rs;
            r_ex_rt        <= bus.id_rt;
            r_ex_rd        <= bus.id_rd;
            r_ex_rs_data   <= i_rd1;
            r_ex_rt_data   <= i_rd2;
            r_ex_imm       <= bus.id_imm;
            r_ex_ctrl      <= bus.id_ctrl;
            r_ex_mem_read  <= bus.id_mem_read;
            r_ex_reg_write <= bus.id_reg_write;
        end else if (r_ex_valid & bus.ex_ready) begin
            r_ex_valid <= 1'b0;
        end else if (r_ex_valid) begin
            if (w_snoop_rs) r_ex_rs_data <= i_wb_data;
            if (w_snoop_rt) r_ex_rt_data <= i_wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (bus.id_valid & w_hazard & ~i_flush & ~&r_stall_cnt)
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign bus.id_ready     = w_id_ready;
    assign bus.ex_valid     = r_ex_valid;
    assign bus.ex_rs        = r_ex_rs;
    assign bus.ex_rt        = r_ex_rt;
    assign bus.ex_rd        = r_ex_rd;
    assign bus.ex_rs_data   = r_ex_rs_data;
    assign bus.ex_rt_data   = r_ex_rt_data;
    assign bus.ex_imm       = r_ex_imm;
    assign bus.ex_ctrl      = r_ex_ctrl;
    assign bus.ex_mem_read  = r_ex_mem_read;
    assign bus.ex_reg_write = r_ex_reg_write;
    assign o_stall_cnt      = r_stall_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed test-plan steps followed by random traffic, checked against an instruction-level model.
module tb_id_ex_stage;
    logic        clk;
    logic        rst_n;
    logic [31:0] rd1, rd2, wb_data;
    logic        flush, mem_reg_write, wb_we;
    logic [4:0]  mem_rd, wb_addr;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;
    int          checks = 0;
    int          failures = 0;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .i_rd1           (rd1),
        .i_rd2           (rd2),
        .i_flush         (flush),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_wb_addr       (wb_addr),
        .i_wb_we         (wb_we),
        .i_wb_data       (wb_data),
        .o_fwd_a         (fwd_a),
        .o_fwd_b         (fwd_b),
        .o_stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, imm;
        logic [7:0]  ctrl;
        logic        mr, rw;
    } instr_t;

    instr_t m;
    int     m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m = '{v: 1'b0, rs: '0, rt: '0, rd: '0, a: '0, b: '0, imm: '0, ctrl: '0, mr: 1'b0, rw: 1'b0};
        m_stall = 0;
    endtask

    function automatic logic m_hazard();
        return m.v && m.mr && m.rd != 0 &&
               ((bus.id_uses_rs && bus.id_rs == m.rd) || (bus.id_uses_rt && bus.id_rt == m.rd));
    endfunction

    function automatic logic m_ready();
        return !flush && !m_hazard() && (!m.v || bus.ex_ready);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        if (!m.v || r == 0) return 2'b00;
        if (mem_reg_write && mem_rd == r) return 2'b10;
        if (wb_we && wb_addr == r) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check_all();
        chk("id_ready", bus.id_ready, m_ready());
        chk("ex_valid", bus.ex_valid, m.v);
        chk("ex_rs", bus.ex_rs, m.rs);
        chk("ex_rt", bus.ex_rt, m.rt);
        chk("ex_rd", bus.ex_rd, m.rd);
        chk("ex_rs_data", bus.ex_rs_data, m.a);
        chk("ex_rt_data", bus.ex_rt_data, m.b);
        chk("ex_imm", bus.ex_imm, m.imm);
        chk("ex_ctrl", bus.ex_ctrl, m.ctrl);
        chk("ex_mem_read", bus.ex_mem_read, m.mr);
        chk("ex_reg_write", bus.ex_reg_write, m.rw);
        chk("fwd_a", fwd_a, m_fwd(m.rs));
        chk("fwd_b", fwd_b, m_fwd(m.rt));
        chk("stall_cnt", stall_cnt, m_stall > 65535 ? 65535 : m_stall);
    endtask

    task automatic update_model();
        logic haz = m_hazard();
        logic rdy = m_ready();
        if (bus.id_valid && haz && !flush) m_stall++;
        if (flush) m.v = 1'b0;
        else if (bus.id_valid && rdy)
            m = '{v: 1'b1, rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd, a: rd1, b: rd2,
                  imm: bus.id_imm, ctrl: bus.id_ctrl, mr: bus.id_mem_read, rw: bus.id_reg_write};
        else if (m.v && bus.ex_ready) m.v = 1'b0;
        else if (m.v) begin
            if (wb_we && wb_addr != 0 && wb_addr == m.rs) m.a = wb_data;
            if (wb_we && wb_addr != 0 && wb_addr == m.rt) m.b = wb_data;
        end
    endtask

    // Inputs are driven at the falling edge; checks land 1 time unit later, well before the rising edge.
    task automatic cycle();
        #1;
        check_all();
        update_model();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic urs, input logic urt, input logic mr, input logic rw);
        bus.id_valid     = v;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_rd        = rd;
        bus.id_uses_rs   = urs;
        bus.id_uses_rt   = urt;
        bus.id_mem_read  = mr;
        bus.id_reg_write = rw;
        bus.id_imm       = $urandom;
        bus.id_ctrl      = 8'($urandom);
        rd1              = $urandom;
        rd2              = $urandom;
    endtask

    task automatic quiet_side();
        flush         = 1'b0;
        mem_rd        = '0;
        mem_reg_write = 1'b0;
        wb_addr       = '0;
        wb_we         = 1'b0;
        wb_data       = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ex_ready = 1'b1;
        quiet_side();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_ex_valid", bus.ex_valid, 1'b0);
        chk("reset_fwd_a", fwd_a, 2'b00);
        chk("reset_id_ready", bus.id_ready, 1'b1);
        rst_n = 1'b1;
        cycle();

        for (int i = 0; i < 4; i++) begin
            set_id(1'b1, 5'(1 + i), 5'(10 + i), 5'(20 + i), 1'b1, 1'b1, 1'b0, 1'b1);
            #1;
            chk("b2b_ready", bus.id_ready, 1'b1);
            cycle();
            chk("b2b_ex_valid", bus.ex_valid, 1'b1);
        end

        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle();
        set_id(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        chk("lu_stall_ready", bus.id_ready, 1'b0);
        cycle();
        chk("lu_bubble", bus.ex_valid, 1'b0);
        chk("lu_stall_cnt", stall_cnt, 16'd1);
        wb_we   = 1'b1;
        wb_addr = 5'd5;
        wb_data = 32'h0000_0555;
        cycle();
        chk("lu_add_in_ex", bus.ex_rs, 5'd5);
        bus.id_valid = 1'b0;
        #1;
        chk("lu_fwd_wb", fwd_a, 2'b01);
        cycle();

        quiet_side();
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle();
        set_id(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle();
        bus.id_valid  = 1'b0;
        bus.ex_ready  = 1'b0;
        mem_rd        = 5'd3;
        mem_reg_write = 1'b1;
        #1;
        chk("mem_fwd_a", fwd_a, 2'b10);
        chk("mem_fwd_b", fwd_b, 2'b10);
        wb_we   = 1'b1;
        wb_addr = 5'd3;
        wb_data = 32'h1234_5678;
        #1;
        chk("mem_wins_a", fwd_a, 2'b10);
        cycle();

        quiet_side();
        bus.ex_ready = 1'b1;
        set_id(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle();
        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b0;
        cycle();
        wb_we   = 1'b1;
        wb_addr = 5'd8;
        wb_data = 32'hDEAD_BEEF;
        cycle();
        wb_we = 1'b0;
        chk("snoop_rs_data", bus.ex_rs_data, 32'hDEAD_BEEF);
        chk("snoop_rd_kept", bus.ex_rd, 5'd10);
        chk("snoop_valid", bus.ex_valid, 1'b1);
        cycle();
        bus.ex_ready = 1'b1;

        set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle();
        set_id(1'b1, 5'd9, 5'd3, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush_ready", bus.id_ready, 1'b0);
        cycle();
        chk("flush_kill", bus.ex_valid, 1'b0);
        flush = 1'b0;
        bus.id_valid = 1'b0;
        cycle();

        set_id(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle();
        bus.id_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.ex_valid, 1'b0);
        chk("async_rst_stall", stall_cnt, 16'd0);
        model_reset();
        rst_n = 1'b1;
        cycle();
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle();
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        chk("r0_no_stall", bus.id_ready, 1'b1);
        cycle();
        chk("r0_stall_cnt", stall_cnt, 16'd0);

        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            bus.ex_ready  = $urandom_range(0, 3) != 0;
            flush         = $urandom_range(0, 15) == 0;
            mem_rd        = 5'($urandom_range(0, 7));
            mem_reg_write = 1'($urandom);
            wb_addr       = 5'($urandom_range(0, 7));
            wb_we         = 1'($urandom);
            wb_data       = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
